// File: rtl/freq_div_ctrl_pkg.sv
// rtl/freq_div_ctrl_pkg.sv - shared definitions for the programmable clock divider
// Holds the controller state encoding and the smallest legal divisor.
package freq_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Smallest divisor that still yields a high and a low phase.
  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_cnt.sv
// rtl/freq_div_cnt.sv - period counter for the clock divider
// Ports:
//   clk_in, reset : clock and asynchronous active-low reset
//   en            : advance the counter this cycle
//   load          : force the counter to 0 (takes priority over en)
//   div           : current divisor; the counter wraps after div-1
//   cnt           : current count
//   wrap          : cnt is at div-1 (combinational decode of the register)
module freq_div_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap = (cnt_q == div - WIDTH'(1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// rtl/freq_div_ctrl.sv - glitch-free programmable clock divider controller
// Ports:
//   clk_in  : single clock, all logic on its rising edge
//   reset   : asynchronous active-low reset
//   run     : 1 = produce clk_out, 0 = stop at the next period boundary
//   cfg_req : level request to change the divisor to cfg_div
//   cfg_div : requested divisor, sampled when the request is accepted
//   cfg_ack : one-cycle completion pulse for a request
//   cfg_err : qualifies cfg_ack; 1 = request rejected (cfg_div below 2)
//   clk_out : registered divided clock, high for div>>1 cycles per period
//   tick    : one-cycle pulse coincident with each rising edge of clk_out
//   busy    : controller is not idle
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_req,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] RST_DIV   = WIDTH'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] cnt;
  logic             cnt_wrap;
  logic             active;
  logic             boundary;
  logic             accept;
  logic             div_bad;
  logic             keep_running;
  logic [WIDTH-1:0] half_q;

  assign active  = (state_q != ST_IDLE);
  // The first RUN cycle is treated as a period boundary: the counter already
  // sits at 0 from IDLE, so this edge starts the first period rather than
  // advancing it.
  assign boundary = active && (start_q || cnt_wrap);
  assign accept   = cfg_req && !ack_q && !pend_vld_q;
  assign div_bad  = (cfg_div < MIN_DIV_W);
  assign half_q   = div_q >> 1;

  freq_div_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (active),
    .load   (start_q),
    .div    (div_q),
    .cnt    (cnt),
    .wrap   (cnt_wrap)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = boundary ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (boundary) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pending divisor is swapped in only at a period boundary, so the
    // period that just ended ran entirely at the old ratio.
    if (boundary && pend_vld_q) begin
      div_d      = pend_div_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end

    // accept cannot coincide with the swap above because it needs an empty
    // pending slot.
    if (accept) begin
      if (div_bad) begin
        ack_d = 1'b1;
        err_d = 1'b1;
      end else if (!active) begin
        div_d = cfg_div;
        ack_d = 1'b1;
      end else begin
        pend_div_d = cfg_div;
        pend_vld_d = 1'b1;
      end
    end

    // Outputs stay low on the IDLE->RUN edge and on any edge that returns
    // to IDLE, which is what keeps the start and stop free of runt pulses.
    keep_running = active && (state_d != ST_IDLE);
    tick_d       = keep_running && boundary;
    // At a boundary the next count is 0, always below half (half >= 1).
    clk_out_d    = keep_running && (boundary || ((cnt + WIDTH'(1)) < half_q));
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      div_q      <= RST_DIV;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb/tb_freq_div_ctrl.sv - directed self-checking bench for freq_div_ctrl
module tb_freq_div_ctrl;

  logic       clk_in  = 1'b0;
  logic       reset   = 1'b0;
  logic       run     = 1'b0;
  logic       cfg_req = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ack;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  freq_div_ctrl #(
    .WIDTH       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .run     (run),
    .cfg_req (cfg_req),
    .cfg_div (cfg_div),
    .cfg_ack (cfg_ack),
    .cfg_err (cfg_err),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  // Expected outputs packed as {clk_out, tick, cfg_ack, cfg_err, busy}.
  typedef struct {
    logic       run;
    logic       req;
    logic [7:0] div;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] outs();
    return {clk_out, tick, cfg_ack, cfg_err, busy};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: clk_out/tick/ack/err/busy got %b required %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic q, input logic [7:0] d, input logic [4:0] e);
    vec_t v;
    v.run = r;
    v.req = q;
    v.div = d;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic q, input logic [7:0] d);
    run     = r;
    cfg_req = q;
    cfg_div = d;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [4:0] e;
    bit         seen;

    // ---- vector table: N=2 run, IDLE config, errors, 5->4 and 4->7 switches
    add(1,0,0, 5'b00001); add(1,0,0, 5'b11001); add(1,0,0, 5'b00001);
    add(1,0,0, 5'b11001); add(1,0,0, 5'b00001);
    add(0,0,0, 5'b00000);                           // stop at wrap -> IDLE
    add(0,1,5, 5'b00100); add(0,0,0, 5'b00000);     // IDLE config, ack next cycle
    add(1,0,0, 5'b00001); add(1,0,0, 5'b11001); add(1,0,0, 5'b10001);
    add(1,0,0, 5'b00001); add(1,0,0, 5'b00001); add(1,0,0, 5'b00001);
    add(1,0,0, 5'b11001); add(1,0,0, 5'b10001);
    add(1,1,1, 5'b00111); add(1,0,0, 5'b00001);     // div=1 rejected
    add(1,1,0, 5'b00111); add(1,0,0, 5'b11001);     // div=0 rejected, period still 5
    add(1,1,4, 5'b10001); add(1,1,4, 5'b00001); add(1,1,4, 5'b00001);
    add(1,1,4, 5'b00001); add(1,1,4, 5'b11101);     // switch to 4 at wrap
    add(1,0,0, 5'b10001); add(1,0,0, 5'b00001); add(1,0,0, 5'b00001);
    add(1,0,0, 5'b11001); add(1,0,0, 5'b10001);
    add(1,1,7, 5'b00001); add(1,1,7, 5'b00001); add(1,1,7, 5'b11101); // 4 -> 7
    add(1,0,0, 5'b10001); add(1,0,0, 5'b10001); add(1,0,0, 5'b00001);
    add(1,0,0, 5'b00001); add(1,0,0, 5'b00001); add(1,0,0, 5'b00001);
    add(1,0,0, 5'b11001);

    // ---- reset state
    step(0, 0, 0);
    step(0, 0, 0);
    check("reset_asserted", outs(), 5'b00000);
    reset = 1'b1;
    step(0, 0, 0);
    check("reset_released_idle", outs(), 5'b00000);

    foreach (vecs[i]) begin
      step(vecs[i].run, vecs[i].req, vecs[i].div);
      check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
    end

    // ---- stop, configure N=6 in IDLE, restart
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 0, 0);
      if (!busy) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL stop_timeout: busy got 1 required 0 within 20 cycles");
    end
    step(0, 1, 6);
    check("idle_cfg6_ack", outs(), 5'b00100);
    step(0, 0, 0);
    step(1, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1, 0, 0);
      if (tick) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL start_timeout: tick got 0 required 1 within 10 cycles");
    end

    // ---- N=6: run dropped for one cycle mid-period, later dropped for good
    for (int i = 1; i <= 18; i++) begin
      step(!(i == 2 || i >= 14), 1'b0, 8'd0);
      if (i < 18) e = {((i % 6) < 3) ? 1'b1 : 1'b0, (i % 6 == 0) ? 1'b1 : 1'b0, 3'b001};
      else        e = 5'b00000;
      check($sformatf("drain6[%0d]", i), outs(), e);
    end

    // ---- reset during DRAIN with a pending request
    step(1, 0, 0);
    step(1, 0, 0);
    check("restart6_tick", outs(), 5'b11001);
    step(1, 0, 0);
    step(0, 1, 3);
    check("drain_with_pend", outs(), 5'b10001);
    step(0, 1, 3);
    #3 reset = 1'b0;
    #1 check("async_reset_mid", outs(), 5'b00000);
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      check($sformatf("no_ack_after_reset[%0d]", i), outs(), 5'b00000);
    end
    step(1, 0, 0);
    check("post_reset_busy", outs(), 5'b00001);
    step(1, 0, 0);
    check("post_reset_tick0", outs(), 5'b11001);
    step(1, 0, 0);
    check("post_reset_low", outs(), 5'b00001);
    step(1, 0, 0);
    check("post_reset_tick1", outs(), 5'b11001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
